// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and state types for the VGA framebuffer path.
// Framebuffer is 160x120 at 8 bpp, each pixel a 4x4 screen block.
package vga_pkg;

  localparam int DEF_H_ACTIVE  = 640;
  localparam int DEF_V_ACTIVE  = 480;
  localparam int FB_W          = 160;
  localparam int FB_H          = 120;
  localparam int FB_DEPTH      = FB_W * FB_H;
  localparam int FB_SCALE_LOG2 = 2;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fb_state_t;

endpackage

// File: rtl/fb_addr_gen.sv
// fb_addr_gen: screen x/y to framebuffer linear address.
// Row stride 160 = 128 + 32, so the multiply is two shifts and adds.
module fb_addr_gen
  import vga_pkg::*;
#(
  parameter int ADDR_W     = 15,
  parameter int SCALE_LOG2 = FB_SCALE_LOG2
) (
  input  logic [9:0]        i_x,
  input  logic [9:0]        i_y,
  output logic [ADDR_W-1:0] o_addr
);

  logic [ADDR_W-1:0] w_xb;
  logic [ADDR_W-1:0] w_yb;

  assign w_xb = ADDR_W'(i_x >> SCALE_LOG2);
  assign w_yb = ADDR_W'(i_y >> SCALE_LOG2);

  assign o_addr = (w_yb << 7) + (w_yb << 5) + w_xb;

endmodule

// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port framebuffer RAM between
// scan-out reads, host writes and a clear/fill engine.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int H_ACTIVE   = DEF_H_ACTIVE,
  parameter int V_ACTIVE   = DEF_V_ACTIVE,
  parameter int SCALE_LOG2 = FB_SCALE_LOG2,
  parameter int ADDR_W     = 15
) (
  input  logic              clock_25,
  input  logic              rst,
  input  logic [9:0]        next_x,
  input  logic [9:0]        next_y,
  output logic [7:0]        color_out,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  output logic              wr_err,
  input  logic              clr_start,
  input  logic [7:0]        clr_color,
  output logic              busy,
  output logic              fill_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  localparam logic [9:0] LP_H = 10'(H_ACTIVE);
  localparam logic [9:0] LP_V = 10'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] LP_DEPTH = ADDR_W'(FB_DEPTH);
  localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(FB_DEPTH - 1);

  fb_state_t r_state;
  fb_state_t w_state_nxt;

  logic [ADDR_W-1:0] r_cnt;
  logic [7:0]        r_fill_color;
  logic [7:0]        r_color;
  logic              r_act_d;
  logic              r_disp_d;
  logic              r_fill_done;
  logic              r_wr_err;

  logic [ADDR_W-1:0] w_disp_addr;
  logic              w_active;
  logic              w_disp;
  logic              w_free;
  logic              w_idle;
  logic              w_rdy;
  logic              w_xfer;
  logic              w_addr_ok;
  logic              w_fill_wr;
  logic              w_fill_last;
  logic              w_start;

  fb_addr_gen #(
    .ADDR_W    (ADDR_W),
    .SCALE_LOG2(SCALE_LOG2)
  ) u_addr (
    .i_x   (next_x),
    .i_y   (next_y),
    .o_addr(w_disp_addr)
  );

  assign w_active = (next_x < LP_H) && (next_y < LP_V);
  assign w_disp   = w_active &&
                    (next_x[SCALE_LOG2-1:0] == '0);
  assign w_free   = !w_disp;
  assign w_idle   = (r_state == IDLE);

  assign w_rdy     = !rst && w_free && w_idle;
  assign w_xfer    = wr_valid && w_rdy;
  assign w_addr_ok = (wr_addr < LP_DEPTH);
  assign w_start   = !rst && w_idle && clr_start;

  assign w_fill_wr   = !rst && w_free && !w_idle;
  assign w_fill_last = w_fill_wr && (r_cnt == LP_LAST);

  // FSM state register
  always_ff @(posedge clock_25) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state: a fill runs until the last address is written
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (clr_start) w_state_nxt = FILL;
      FILL: if (w_fill_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM outputs: RAM port mux; display slot keeps the read address
  always_comb begin
    ram_addr  = w_disp_addr;
    ram_we    = 1'b0;
    ram_wdata = '0;
    unique case (1'b1)
      w_fill_wr: begin
        ram_we    = 1'b1;
        ram_addr  = r_cnt;
        ram_wdata = r_fill_color;
      end
      (w_xfer && w_addr_ok): begin
        ram_we    = 1'b1;
        ram_addr  = wr_addr;
        ram_wdata = wr_data;
      end
      default: ;
    endcase
  end

  // fill counter, latched colour and one-cycle status pulses
  always_ff @(posedge clock_25) begin
    if (rst) begin
      r_cnt        <= '0;
      r_fill_color <= '0;
      r_fill_done  <= 1'b0;
      r_wr_err     <= 1'b0;
    end else begin
      r_fill_done <= w_fill_last;
      r_wr_err    <= w_xfer && !w_addr_ok;
      if (w_start) begin
        r_cnt        <= '0;
        r_fill_color <= clr_color;
      end else if (w_fill_wr) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // colour pipeline: flags ride alongside the RAM read by one cycle
  always_ff @(posedge clock_25) begin
    if (rst) begin
      r_act_d  <= 1'b0;
      r_disp_d <= 1'b0;
      r_color  <= '0;
    end else begin
      r_act_d  <= w_active;
      r_disp_d <= w_disp;
      if (r_disp_d) begin
        r_color <= ram_rdata;
      end else if (!r_act_d) begin
        r_color <= '0;
      end
    end
  end

  assign wr_ready  = w_rdy;
  assign wr_err    = r_wr_err;
  assign busy      = !w_idle;
  assign fill_done = r_fill_done;
  assign color_out = r_color;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter: scoreboard bench for the framebuffer arbiter.
// Bench owns the RAM and a reference framebuffer image.
module tb_vga_fb_arbiter;

  logic        clock_25 = 1'b0;
  logic        rst;
  logic [9:0]  next_x;
  logic [9:0]  next_y;
  logic [7:0]  color_out;
  logic        wr_valid;
  logic        wr_ready;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_err;
  logic        clr_start;
  logic [7:0]  clr_color;
  logic        busy;
  logic        fill_done;
  logic [14:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  logic preload = 1'b0;

  logic [7:0] mem    [0:32767];
  logic [7:0] refmem [0:32767];
  logic [7:0] m_grp = 8'h00;

  typedef struct {
    int          cyc;
    bit          rdy;
    bit          we;
    bit          ca;
    logic [14:0] addr;
    bit          cd;
    logic [7:0]  data;
  } port_t;

  typedef struct {
    int         cyc;
    logic [7:0] col;
  } col_t;

  port_t port_q[$];
  col_t  col_q[$];
  int    err_q[$];
  port_t mp;
  col_t  mc;

  always #5 clock_25 = ~clock_25;

  vga_fb_arbiter dut (
    .clock_25 (clock_25),
    .rst      (rst),
    .next_x   (next_x),
    .next_y   (next_y),
    .color_out(color_out),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_err   (wr_err),
    .clr_start(clr_start),
    .clr_color(clr_color),
    .busy     (busy),
    .fill_done(fill_done),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // single-port RAM, read-first, one cycle read latency
  always @(posedge clock_25) begin
    cyc <= cyc + 1;
    if (preload) begin
      for (int i = 0; i < 32768; i++) mem[i] <= i[7:0];
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
  end

  always @(negedge clock_25) begin
    if (fill_done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(string nm, bit ok, int act, int exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // monitor: pops expectations due in the current cycle
  always @(negedge clock_25) begin
    while (port_q.size() > 0 && port_q[0].cyc < cyc) begin
      chk("port_missed", 1'b0, port_q[0].cyc, cyc);
      void'(port_q.pop_front());
    end
    if (port_q.size() > 0 && port_q[0].cyc == cyc) begin
      mp = port_q.pop_front();
      chk("ram_port",
          wr_ready == mp.rdy && ram_we == mp.we &&
          (!mp.ca || ram_addr == mp.addr) &&
          (!mp.cd || ram_wdata == mp.data),
          int'({wr_ready, ram_we, ram_addr, ram_wdata}),
          int'({mp.rdy, mp.we, mp.addr, mp.data}));
    end
    while (col_q.size() > 0 && col_q[0].cyc < cyc) begin
      chk("color_missed", 1'b0, col_q[0].cyc, cyc);
      void'(col_q.pop_front());
    end
    if (col_q.size() > 0 && col_q[0].cyc == cyc) begin
      mc = col_q.pop_front();
      chk("color_out", color_out == mc.col,
          int'(color_out), int'(mc.col));
    end
    while (err_q.size() > 0 && err_q[0] < cyc) begin
      chk("wr_err_missing", 1'b0, 0, 1);
      void'(err_q.pop_front());
    end
    if (wr_err) begin
      if (err_q.size() > 0 && err_q[0] == cyc) begin
        void'(err_q.pop_front());
        chk("wr_err", 1'b1, 1, 1);
      end else begin
        chk("wr_err_spurious", 1'b0, 1, 0);
      end
    end
  end

  task automatic tick();
    @(posedge clock_25);
    #1;
  endtask

  function automatic bit m_active(int x, int y);
    return x < 640 && y < 480;
  endfunction

  // one idle-state cycle: predict port, colour and error, then advance
  task automatic cyc_step(int x, int y, bit v, int a, int d);
    port_t e;
    col_t  c;
    bit    disp;
    next_x   = 10'(x);
    next_y   = 10'(y);
    wr_valid = v;
    wr_addr  = 15'(a);
    wr_data  = 8'(d);
    disp = m_active(x, y) && (x % 4 == 0);
    e.cyc = cyc;
    e.rdy = !rst && !disp;
    e.we = 1'b0;
    e.ca = 1'b0;
    e.addr = '0;
    e.cd = 1'b0;
    e.data = '0;
    if (disp) begin
      e.ca = 1'b1;
      e.addr = 15'((y / 4) * 160 + x / 4);
      m_grp = refmem[(y / 4) * 160 + x / 4];
    end else if (v && e.rdy) begin
      if (a < 19200) begin
        e.we = 1'b1;
        e.ca = 1'b1;
        e.addr = 15'(a);
        e.cd = 1'b1;
        e.data = 8'(d);
        refmem[a] = 8'(d);
      end else begin
        err_q.push_back(cyc + 1);
      end
    end
    port_q.push_back(e);
    c.cyc = cyc + 2;
    c.col = m_active(x, y) ? m_grp : 8'h00;
    col_q.push_back(c);
    tick();
  endtask

  task automatic cmp_mem(string nm);
    int bad = 0;
    int first = -1;
    for (int i = 0; i < 32768; i++) begin
      if (mem[i] !== refmem[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    end
    chk(nm, bad == 0, bad, 0);
    if (bad != 0) $display("  first bad addr %0d", first);
  endtask

  task automatic wait_fill(output int n);
    n = 0;
    while (busy && n < 20000) begin
      n++;
      tick();
    end
  endtask

  initial begin
    #1500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int d0;
    int r;
    int a;
    rst = 1'b1;
    next_x = 10'd700;
    next_y = 10'd500;
    wr_valid = 1'b1;
    wr_addr = 15'd10;
    wr_data = 8'h01;
    clr_start = 1'b0;
    clr_color = 8'h00;
    preload = 1'b1;
    for (int i = 0; i < 32768; i++) refmem[i] = i[7:0];
    tick();
    preload = 1'b0;

    for (int i = 0; i < 3; i++) cyc_step(700, 500, 1, 10, 1);
    #1;
    chk("rst_color", color_out == 8'h00, int'(color_out), 0);
    chk("rst_busy", busy == 1'b0, int'(busy), 0);
    chk("rst_done", fill_done == 1'b0, int'(fill_done), 0);
    chk("rst_err", wr_err == 1'b0, int'(wr_err), 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) cyc_step(700, 500, 0, 0, 0);

    for (int x = 0; x < 800; x++) cyc_step(x, 8, 0, 0, 0);

    for (int x = 0; x < 800; x++) begin
      r = $urandom_range(0, 3);
      case (r)
        0: a = 320 + $urandom_range(0, 159);
        1: a = $urandom_range(0, 19199);
        2: a = 19200 + $urandom_range(0, 200);
        default: a = $urandom_range(0, 32767);
      endcase
      cyc_step(x, 9, 1'($urandom_range(0, 1)), a,
               $urandom_range(0, 255));
    end

    for (int x = 0; x < 8; x++)
      cyc_step(x, 12, 1, 1000 + x, 128 + x);
    for (int x = 8; x < 800; x++) cyc_step(x, 12, 0, 0, 0);

    cyc_step(700, 500, 1, 19200, 8'hAA);
    cyc_step(700, 500, 0, 0, 0);
    cyc_step(700, 500, 0, 0, 0);
    cmp_mem("mem_after_scan");

    wr_valid = 1'b0;
    d0 = done_cnt;
    clr_start = 1'b1;
    clr_color = 8'hE4;
    tick();
    clr_start = 1'b0;
    n = 0;
    while (busy && n < 20000) begin
      n++;
      clr_start = (n == 5000);
      clr_color = 8'h99;
      tick();
    end
    clr_start = 1'b0;
    chk("fill_busy_cycles", n == 19200, n, 19200);
    chk("fill_done_edge", fill_done == 1'b1, int'(fill_done), 1);
    tick();
    tick();
    chk("fill_done_count", done_cnt - d0 == 1, done_cnt - d0, 1);
    for (int i = 0; i < 19200; i++) refmem[i] = 8'hE4;
    cmp_mem("mem_after_fill");

    clr_start = 1'b1;
    clr_color = 8'h5A;
    tick();
    clr_start = 1'b0;
    repeat (100) tick();
    rst = 1'b1;
    tick();
    chk("midrst_busy", busy == 1'b0, int'(busy), 0);
    chk("midrst_color", color_out == 8'h00, int'(color_out), 0);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) refmem[i] = 8'h5A;
    cmp_mem("mem_after_midrst");

    clr_start = 1'b1;
    clr_color = 8'h11;
    tick();
    clr_start = 1'b0;
    #1;
    chk("restart_addr0", ram_we && ram_addr == 15'd0 &&
        ram_wdata == 8'h11,
        int'({ram_we, ram_addr, ram_wdata}),
        int'({1'b1, 15'd0, 8'h11}));
    wait_fill(n);
    chk("refill_busy_cycles", n == 19200, n, 19200);
    for (int i = 0; i < 19200; i++) refmem[i] = 8'h11;
    cmp_mem("mem_after_refill");

    wr_valid = 1'b1;
    wr_addr = 15'd5;
    wr_data = 8'h3C;
    clr_start = 1'b1;
    clr_color = 8'h77;
    #1;
    chk("simul_host_wr", wr_ready && ram_we && ram_addr == 15'd5 &&
        ram_wdata == 8'h3C,
        int'({wr_ready, ram_we, ram_addr, ram_wdata}),
        int'({1'b1, 1'b1, 15'd5, 8'h3C}));
    tick();
    wr_valid = 1'b0;
    clr_start = 1'b0;
    #1;
    chk("simul_mem5", mem[5] == 8'h3C, int'(mem[5]), 8'h3C);
    chk("simul_fill0", busy && ram_we && ram_addr == 15'd0 &&
        ram_wdata == 8'h77,
        int'({busy, ram_we, ram_addr, ram_wdata}),
        int'({1'b1, 1'b1, 15'd0, 8'h77}));
    repeat (8) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) refmem[i] = 8'h77;
    cmp_mem("mem_after_simul");

    repeat (4) tick();
    chk("port_q_drained", port_q.size() == 0, port_q.size(), 0);
    chk("col_q_drained", col_q.size() == 0, col_q.size(), 0);
    chk("err_q_drained", err_q.size() == 0, err_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
